// File: rtl/byte_serializer.sv
// Parallel-in, serial-out word drainer with valid/ready on both the load and serial sides.
// Optional even-parity trailer bit is built when BYTE_SERIALIZER_PARITY_EN is defined.
module byte_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter logic        LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   input  logic             sout_ready,
   output logic             busy,
   output logic             done
);

   // Handshakes: a word is accepted on a cycle with load_valid && load_ready; a bit
   // moves on a cycle with sout_valid && sout_ready. Nothing moves on any other cycle.
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef BYTE_SERIALIZER_PARITY_EN
   localparam logic [1:0] S_PAR   = 2'd2;
`endif
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BYTE_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (load_valid) begin
               shreg_d = d;
               cnt_d   = '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
               par_d   = ^d;
`endif
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (sout_ready) begin
               shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
               // Counter holds at its last value instead of wrapping at the final bit.
               if (cnt_q == CNT_LAST) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef BYTE_SERIALIZER_PARITY_EN
         S_PAR: begin
            if (sout_ready) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef BYTE_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // All outputs decode from state and register only; sout_ready never reaches them.
   always_comb begin
      sout = 1'b0;
      if (state_q == S_SHIFT) sout = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef BYTE_SERIALIZER_PARITY_EN
      if (state_q == S_PAR) sout = par_q;
`endif
   end

`ifdef BYTE_SERIALIZER_PARITY_EN
   assign sout_valid = (state_q == S_SHIFT) || (state_q == S_PAR);
`else
   assign sout_valid = (state_q == S_SHIFT);
`endif
   assign load_ready = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: an LSB-first and an MSB-first instance share stimulus;
// per-bit scoreboards check the serial streams, tasks check timing and handshakes.
module tb_byte_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d;
   logic       load_valid;
   logic       sout_ready;
   logic       load_ready, sout, sout_valid, busy, done;
   logic       load_ready_m, sout_m, sout_valid_m, busy_m, done_m;

`ifdef BYTE_SERIALIZER_PARITY_EN
   localparam int BASE_LAT = 10;
`else
   localparam int BASE_LAT = 9;
`endif

   byte_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready),
      .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .busy(busy), .done(done)
   );

   byte_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready_m),
      .sout(sout_m), .sout_valid(sout_valid_m), .sout_ready(sout_ready), .busy(busy_m), .done(done_m)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [0:0] exp_q[$];
   logic [0:0] exp_m_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_word(input logic [7:0] w, input logic p);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
      for (int i = 7; i >= 0; i--) exp_m_q.push_back(w[i]);
`ifdef BYTE_SERIALIZER_PARITY_EN
      exp_q.push_back(p);
      exp_m_q.push_back(p);
`else
      if (p === 1'bx) $display("note: parity value unknown");
`endif
   endtask

   // Scoreboards: pop on every accepted serial transfer, and verify stall stability.
   logic hold_chk = 1'b0;
   logic held_bit = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (sout_valid && sout_ready) begin
            if (exp_q.size() == 0) check("lsb_unexpected_bit", 1, 0);
            else check("lsb_sout_bit", sout, exp_q.pop_front());
         end
         if (hold_chk && sout_valid) check("stall_hold", sout, held_bit);
         hold_chk = sout_valid && !sout_ready;
         held_bit = sout;
         if (done) check("lsb_done_drained", exp_q.size(), 0);
         if (sout_valid_m && sout_ready) begin
            if (exp_m_q.size() == 0) check("msb_unexpected_bit", 1, 0);
            else check("msb_sout_bit", sout_m, exp_m_q.pop_front());
         end
         if (done_m) check("msb_done_drained", exp_m_q.size(), 0);
      end
   end

   // Entered at posedge+1 with both instances idle; returns at posedge+1 in cycle 1.
   task automatic do_accept(input logic [7:0] w, input logic p);
      d = w;
      load_valid = 1'b1;
      @(negedge clk);
      check("load_ready_idle", load_ready, 1);
      push_word(w, p);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      d = 8'($urandom_range(0, 255));
      check("load_ready_drop", load_ready, 0);
   endtask

   task automatic wait_done(input int mode, input int exp_lat);
      int cyc = 1;
      int busy_n = 0;
      int busy_mn = 0;
      bit seen = 1'b0;
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      while (!seen && cyc <= 200) begin
         case (mode)
            0: sout_ready = 1'b1;
            1: sout_ready = pat[(cyc - 1) % 6];
            default: sout_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         check("load_ready_busy", load_ready, 0);
         if (busy) busy_n++;
         if (busy_m) busy_mn++;
         if (done) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
      else if (exp_lat >= 0) begin
         check("done_latency", cyc, exp_lat);
         check("lsb_busy_cycles", busy_n, exp_lat);
         check("msb_busy_cycles", busy_mn, exp_lat);
      end
      @(posedge clk);
      #1;
      check("load_ready_back", load_ready, 1);
      check("busy_clear", busy, 0);
      check("done_one_cycle", done, 0);
      check("msb_done_one_cycle", done_m, 0);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       par;
      int         mode;
      int         lat;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{d: 8'hA5, par: 1'b0, mode: 0, lat: BASE_LAT};
      vecs[1] = '{d: 8'h81, par: 1'b0, mode: 0, lat: BASE_LAT};
      vecs[2] = '{d: 8'h3C, par: 1'b0, mode: 1, lat: -1};
      vecs[3] = '{d: 8'h07, par: 1'b1, mode: 0, lat: BASE_LAT};
      vecs[4] = '{d: 8'h03, par: 1'b0, mode: 0, lat: BASE_LAT};
      vecs[5] = '{d: 8'h00, par: 1'b0, mode: 2, lat: -1};
      vecs[6] = '{d: 8'hFF, par: 1'b0, mode: 0, lat: BASE_LAT};
      vecs[7] = '{d: 8'h5A, par: 1'b0, mode: 2, lat: -1};

      rst = 1'b1;
      d = 8'h00;
      load_valid = 1'b0;
      sout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_load_ready", load_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_sout_valid", sout_valid, 0);
      check("rst_sout", sout, 0);
      check("rst_done", done, 0);
      check("rst_msb_sout_valid", sout_valid_m, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_accept(vecs[i].d, vecs[i].par);
         wait_done(vecs[i].mode, vecs[i].lat);
      end

      for (int i = 0; i < 4; i++) begin
         logic [7:0] w;
         w = 8'($urandom_range(0, 255));
         do_accept(w, ^w);
         wait_done(2, -1);
      end

      // Load held high during a word: the second word waits for IDLE.
      d = 8'hC3;
      load_valid = 1'b1;
      @(negedge clk);
      check("hold_first_accept", load_ready, 1);
      push_word(8'hC3, 1'b0);
      @(posedge clk);
      #1;
      d = 8'hFF;
      wait_done(0, BASE_LAT);
      do_accept(8'hFF, 1'b0);
      wait_done(0, BASE_LAT);

      // Asynchronous reset between edges after three bits.
      do_accept(8'h5A, 1'b0);
      sout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      exp_m_q.delete();
      #1;
      check("arst_sout_valid", sout_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_load_ready", load_ready, 1);
      check("arst_msb_busy", busy_m, 0);
      #1;
      rst = 1'b0;
      sout_ready = 1'b0;
      @(negedge clk);
      check("arst_no_partial", sout_valid, 0);
      @(posedge clk);
      #1;
      do_accept(8'h0F, 1'b0);
      wait_done(0, BASE_LAT);

      check("final_lsb_queue", exp_q.size(), 0);
      check("final_msb_queue", exp_m_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Parallel-in, serial-out reader that drains a latched byte bus onto a single serial line. Sits downstream of the 8-bit latch register: it accepts a byte over a valid/ready load handshake, then emits it one bit per accepted transfer on a serial valid/ready interface. It signals busy while shifting and pulses done when the word, and parity if enabled, has fully left.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..16.
LSB_FIRST, 1, bit order: 1 sends d[0] first, 0 sends d[WIDTH-1] first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high.
d  input  WIDTH  parallel word to serialize; sampled only on load accept.
load_valid  input  1  upstream has a word on d.
load_ready  output  1  serializer can accept a word (high only in IDLE).
sout  output  1  current serial bit.
sout_valid  output  1  sout carries a valid bit.
sout_ready  input  1  downstream consumes sout this cycle.
busy  output  1  a word is in flight (any state except IDLE).
done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1. Reset asserted mid-word aborts the word immediately. No partial bits are emitted after reset releases.
- States: IDLE, SHIFT, PAR (present only with PARITY_EN), DONE.
- IDLE: load_ready=1, sout_valid=0.
  - load_valid=1 latches d into the shift register and clears the counter. Next state is SHIFT.
  - Latency: the first bit is valid on sout on the cycle after accept.
- SHIFT: sout_valid=1. sout is shreg[0] when LSB_FIRST=1, otherwise shreg[WIDTH-1].
  - A bit transfers only on a cycle where sout_valid=1 and sout_ready=1. On transfer the register shifts by one and the counter increments.
  - sout_ready=0 stalls: sout, the counter and the register are held stable for any number of cycles.
  - On the transfer with counter==WIDTH-1, the next state is PAR if PARITY_EN is defined, otherwise DONE.
- DONE: lasts one cycle with done=1, sout_valid=0, busy=1, load_ready=0. Next state is IDLE. The earliest next accept is the cycle after DONE.
- load_valid while busy is ignored; d is not sampled.
- busy=1 in SHIFT, PAR and DONE.
- d changing after accept has no effect on the word in flight.
- Bit counter width is clog2(WIDTH). It never wraps within a word.
- The counter and register clear on accept, not on DONE.
- All outputs except load_ready and busy are registered or decoded from the state and register only; there is no combinational path from sout_ready to sout_valid.
- Throughput with sout_ready held at 1: one word per WIDTH+2 cycles, or WIDTH+3 with parity.

Optional Feature:
Macro BYTE_SERIALIZER_PARITY_EN.
- Defined:
  - Even parity (XOR of all WIDTH data bits, computed at accept) is sent as one extra bit in state PAR after the data bits.
  - PAR uses the same valid/ready transfer and stall rules as SHIFT.
  - After the parity transfer the next state is DONE.
- Undefined: state PAR and the parity logic are absent; SHIFT goes directly to DONE.

Test Plan:
- Reset release, then d=8'hA5, load_valid=1 for one cycle, sout_ready=1 -> load_ready drops the next cycle. sout sequence over 8 cycles is 1,0,1,0,0,1,0,1 (LSB first). done pulses once, 9 cycles after accept; load_ready returns to 1 the cycle after done.
- LSB_FIRST=0, d=8'h81 -> sout sequence is 1,0,0,0,0,0,0,1. busy is high for exactly 9 cycles (8 bits + DONE).
- d=8'h3C accepted, sout_ready toggled 1,0,0,1,0,1,... -> sout is held stable during stalls and no bit is skipped or duplicated. The received byte is 8'h3C. done fires only after the 8th accepted transfer.
- Word in flight, load_valid=1 with d=8'hFF held throughout -> second word is not accepted until IDLE. The first word is received intact, then 8'hFF is accepted on the first IDLE cycle.
- rst pulsed asynchronously (between clock edges) after 3 bits of 8'h5A -> sout_valid, busy and done go to 0 immediately and load_ready=1. The next word 8'h0F serializes correctly from bit 0.
- PARITY_EN defined: d=8'h07 -> 8 data bits followed by parity bit 1. d=8'h03 -> parity bit 0. done comes 10 cycles after accept with sout_ready=1.
